// File: rtl/exe_alu_stage.sv
// ---------------------------------------------------------------------------
// exe_alu_stage
//
// Integer execute stage: picks the operands, runs the ALU, resolves the
// branch and registers the resulting beat. The stage has a one-cycle latency
// and uses valid/ready handshakes on both sides. An output register drives
// the result interface. A skid register holds one extra uop, so in_ready is
// a registered signal and does not depend on out_ready through logic.
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   in_valid/ready upstream handshake (transfer when both high)
//   in_alufn       ALU function
//   in_opr1        operand-1 select (zero / pc / rs1)
//   in_opr2        operand-2 select (imm / rs2)
//   in_brfn        branch function (none / jalr / conditional)
//   in_rs1, in_rs2 register source values
//   in_pc          uop PC
//   in_imm         sign-extended immediate
//   in_tag         ROB tag carried with the uop
//   in_pred_taken  front-end taken prediction
//   flush          kill every in-flight uop
//   out_valid/ready downstream handshake
//   out_result     writeback value
//   out_tag        ROB tag of the beat
//   out_redirect   mispredict indication (qualified by out_valid)
//   out_target     correct next PC when out_redirect
// ---------------------------------------------------------------------------
package exe_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SL, ALU_SR, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_XORO, ALU_ORO, ALU_ANDO
  } alufnt;

  typedef enum logic [1:0] {OPR1_ZERO, OPR1_PC, OPR1_RS1} opr1t;

  typedef enum logic {OPR2_IMM, OPR2_RS2} opr2t;

  typedef enum logic [2:0] {
    BR_NONE, BR_JALR, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } brfnt;

endpackage

module exe_alu_stage
  import exe_alu_pkg::*;
#(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alufnt            in_alufn,
  input  opr1t             in_opr1,
  input  opr2t             in_opr2,
  input  brfnt             in_brfn,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_imm,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_pred_taken,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_redirect,
  output logic [31:0]      out_target
);

  typedef struct packed {
    logic [31:0]      result;
    logic [31:0]      target;
    logic             redirect;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] alu_res;
  logic [31:0] pc_plus4;
  logic [31:0] jalr_sum;
  logic        taken;
  beat_t       new_beat;

  beat_t       out_q;
  beat_t       skid_q;
  logic        out_valid_q;
  logic        skid_valid_q;
  logic        accept;
  logic        out_free;

  // Operand selection and the ALU proper.
  always_comb begin
    op1 = '0;
    op2 = in_imm;
    case (in_opr1)
      OPR1_PC:  op1 = in_pc;
      OPR1_RS1: op1 = in_rs1;
      default:  op1 = '0;
    endcase
    if (in_opr2 == OPR2_RS2) op2 = in_rs2;

    alu_res = '0;
    case (in_alufn)
      ALU_ADD:  alu_res = op1 + op2;
      ALU_SUB:  alu_res = op1 - op2;
      ALU_SL:   alu_res = op1 << op2[4:0];
      ALU_SR:   alu_res = op1 >> op2[4:0];
      ALU_SRA:  alu_res = 32'($signed(op1) >>> op2[4:0]);
      ALU_SLT:  alu_res = {31'd0, $signed(op1) < $signed(op2)};
      ALU_SLTU: alu_res = {31'd0, op1 < op2};
      ALU_XORO: alu_res = op1 ^ op2;
      ALU_ORO:  alu_res = op1 | op2;
      ALU_ANDO: alu_res = op1 & op2;
      default:  alu_res = '0;
    endcase
  end

  // Branch resolution. Conditional branches always compare rs1 with rs2,
  // independent of the operand selects, which only steer the target adder.
  // jalr always redirects because the front end has no indirect predictor.
  always_comb begin
    pc_plus4 = in_pc + 32'd4;
    jalr_sum = in_rs1 + in_imm;
    taken    = 1'b0;
    case (in_brfn)
      BR_BEQ:  taken = (in_rs1 == in_rs2);
      BR_BNE:  taken = (in_rs1 != in_rs2);
      BR_BLT:  taken = ($signed(in_rs1) < $signed(in_rs2));
      BR_BGE:  taken = ($signed(in_rs1) >= $signed(in_rs2));
      BR_BLTU: taken = (in_rs1 < in_rs2);
      BR_BGEU: taken = (in_rs1 >= in_rs2);
      default: taken = 1'b0;
    endcase

    new_beat.tag      = in_tag;
    new_beat.result   = alu_res;
    new_beat.target   = pc_plus4;
    new_beat.redirect = 1'b0;
    case (in_brfn)
      BR_NONE: ;
      BR_JALR: begin
        new_beat.result   = pc_plus4;
        new_beat.target   = jalr_sum & ~32'd1;
        new_beat.redirect = 1'b1;
      end
      default: begin
        new_beat.result   = '0;
        new_beat.target   = taken ? alu_res : pc_plus4;
        new_beat.redirect = taken ^ in_pred_taken;
      end
    endcase
  end

  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid_q || out_ready;

  // Output slot plus skid register. When the slot drains, the skid entry
  // moves forward first. No new uop can arrive in that cycle because
  // in_ready was low. A stalled slot sends an accepted uop to the skid.
  // Flush clears only the valid bits, and reset also clears the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (accept) begin
        out_q       <= new_beat;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (accept) begin
      skid_q       <= new_beat;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = out_q.result;
  assign out_tag      = out_q.tag;
  assign out_redirect = out_q.redirect;
  assign out_target   = out_q.target;

endmodule

// File: tb/tb_exe_alu_stage.sv
// ---------------------------------------------------------------------------
// tb_exe_alu_stage
//
// Directed testbench for exe_alu_stage. Each vector carries an expected
// value worked out by hand. Outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_exe_alu_stage;
  import exe_alu_pkg::*;

  localparam int TAG_W = 6;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  alufnt            in_alufn;
  opr1t             in_opr1;
  opr2t             in_opr2;
  brfnt             in_brfn;
  logic [31:0]      in_rs1;
  logic [31:0]      in_rs2;
  logic [31:0]      in_pc;
  logic [31:0]      in_imm;
  logic [TAG_W-1:0] in_tag;
  logic             in_pred_taken;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_redirect;
  logic [31:0]      out_target;

  int checks_done;
  int checks_failed;

  exe_alu_stage #(.TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_alufn(in_alufn),
    .in_opr1(in_opr1),
    .in_opr2(in_opr2),
    .in_brfn(in_brfn),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_pc(in_pc),
    .in_imm(in_imm),
    .in_tag(in_tag),
    .in_pred_taken(in_pred_taken),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_tag(out_tag),
    .out_redirect(out_redirect),
    .out_target(out_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value with its expected value and logs a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks_done++;
    if (actual !== expected) begin
      checks_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Presents one uop on the input side with in_valid high. No clock is applied.
  task automatic applyStimulus(input alufnt fn, input opr1t o1, input opr2t o2,
                               input brfnt br, input logic [31:0] rs1,
                               input logic [31:0] rs2, input logic [31:0] pc,
                               input logic [31:0] imm, input int tag,
                               input logic pred);
    in_alufn      = fn;
    in_opr1       = o1;
    in_opr2       = o2;
    in_brfn       = br;
    in_rs1        = rs1;
    in_rs2        = rs2;
    in_pc         = pc;
    in_imm        = imm;
    in_tag        = TAG_W'(tag);
    in_pred_taken = pred;
    in_valid      = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Empties the stage: nothing offered, downstream always ready.
  task automatic drainIdle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  // Pushes one uop through an idle stage and leaves the result on out_*.
  task automatic issueOne(input alufnt fn, input opr1t o1, input opr2t o2,
                          input brfnt br, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic [31:0] pc,
                          input logic [31:0] imm, input int tag,
                          input logic pred);
    applyStimulus(fn, o1, o2, br, rs1, rs2, pc, imm, tag, pred);
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    checks_done   = 0;
    checks_failed = 0;
    rst           = 1'b1;
    flush         = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b1;
    in_alufn      = ALU_ADD;
    in_opr1       = OPR1_ZERO;
    in_opr2       = OPR2_IMM;
    in_brfn       = BR_NONE;
    in_rs1        = '0;
    in_rs2        = '0;
    in_pc         = '0;
    in_imm        = '0;
    in_tag        = '0;
    in_pred_taken = 1'b0;

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_result", out_result, 32'd0);
    checkOutput("rst_tag", 32'(out_tag), 32'd0);
    checkOutput("rst_redirect", 32'(out_redirect), 32'd0);
    checkOutput("rst_target", out_target, 32'd0);

    // addi rs1=5 imm=-3 gives 2
    issueOne(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd5, 32'd0, 32'h0,
             32'hFFFF_FFFD, 11, 1'b0);
    checkOutput("addi_valid", 32'(out_valid), 32'd1);
    checkOutput("addi_result", out_result, 32'd2);
    checkOutput("addi_redirect", 32'(out_redirect), 32'd0);
    checkOutput("addi_tag", 32'(out_tag), 32'd11);

    // bltu 1 < 0xFFFFFFFF is taken. A not-taken prediction must redirect.
    issueOne(ALU_ADD, OPR1_PC, OPR2_IMM, BR_BLTU, 32'd1, 32'hFFFF_FFFF,
             32'h100, 32'h20, 12, 1'b0);
    checkOutput("bltu_np_redirect", 32'(out_redirect), 32'd1);
    checkOutput("bltu_np_target", out_target, 32'h120);
    checkOutput("bltu_np_result", out_result, 32'd0);
    issueOne(ALU_ADD, OPR1_PC, OPR2_IMM, BR_BLTU, 32'd1, 32'hFFFF_FFFF,
             32'h100, 32'h20, 13, 1'b1);
    checkOutput("bltu_p_redirect", 32'(out_redirect), 32'd0);
    checkOutput("bltu_p_target", out_target, 32'h120);

    // beq with 1 != 2 is not taken. A taken prediction redirects to pc+4.
    issueOne(ALU_ADD, OPR1_PC, OPR2_IMM, BR_BEQ, 32'd1, 32'd2, 32'h200,
             32'h40, 14, 1'b1);
    checkOutput("beq_redirect", 32'(out_redirect), 32'd1);
    checkOutput("beq_target", out_target, 32'h204);

    // blt -1 < 1 (signed) is taken. bltu of the same values is not taken.
    issueOne(ALU_ADD, OPR1_PC, OPR2_IMM, BR_BLT, 32'hFFFF_FFFF, 32'd1,
             32'h300, 32'hFFFF_FFF0, 15, 1'b0);
    checkOutput("blt_redirect", 32'(out_redirect), 32'd1);
    checkOutput("blt_target", out_target, 32'h2F0);
    issueOne(ALU_ADD, OPR1_PC, OPR2_IMM, BR_BGEU, 32'hFFFF_FFFF, 32'd1,
             32'h300, 32'h10, 16, 1'b1);
    checkOutput("bgeu_redirect", 32'(out_redirect), 32'd0);
    checkOutput("bgeu_target", out_target, 32'h310);

    // jalr rs1=0x1003 imm=4 pc=0x40
    issueOne(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_JALR, 32'h1003, 32'd0, 32'h40,
             32'd4, 17, 1'b0);
    checkOutput("jalr_result", out_result, 32'h44);
    checkOutput("jalr_target", out_target, 32'h1006);
    checkOutput("jalr_redirect", 32'(out_redirect), 32'd1);

    // sra uses only shamt = 0x24 & 31 = 4
    issueOne(ALU_SRA, OPR1_RS1, OPR2_RS2, BR_NONE, 32'h8000_0000, 32'h24,
             32'h0, 32'h0, 18, 1'b0);
    checkOutput("sra_result", out_result, 32'hF800_0000);
    issueOne(ALU_SR, OPR1_RS1, OPR2_RS2, BR_NONE, 32'h8000_0000, 32'h24,
             32'h0, 32'h0, 19, 1'b0);
    checkOutput("sr_result", out_result, 32'h0800_0000);
    issueOne(ALU_SL, OPR1_RS1, OPR2_IMM, BR_NONE, 32'h0000_0003, 32'h0,
             32'h0, 32'h1F, 20, 1'b0);
    checkOutput("sl_result", out_result, 32'h8000_0000);
    issueOne(ALU_SUB, OPR1_RS1, OPR2_RS2, BR_NONE, 32'd3, 32'd5, 32'h0,
             32'h0, 21, 1'b0);
    checkOutput("sub_result", out_result, 32'hFFFF_FFFE);
    issueOne(ALU_SLT, OPR1_RS1, OPR2_RS2, BR_NONE, 32'hFFFF_FFFF, 32'd1,
             32'h0, 32'h0, 22, 1'b0);
    checkOutput("slt_result", out_result, 32'd1);
    issueOne(ALU_SLTU, OPR1_RS1, OPR2_RS2, BR_NONE, 32'hFFFF_FFFF, 32'd1,
             32'h0, 32'h0, 23, 1'b0);
    checkOutput("sltu_result", out_result, 32'd0);
    issueOne(ALU_XORO, OPR1_RS1, OPR2_RS2, BR_NONE, 32'hF0F0_1234, 32'h0FF0_FFFF,
             32'h0, 32'h0, 24, 1'b0);
    checkOutput("xor_result", out_result, 32'hFF00_EDCB);
    issueOne(ALU_ANDO, OPR1_PC, OPR2_IMM, BR_NONE, 32'h0, 32'h0,
             32'h1234_5678, 32'h0000_FF00, 25, 1'b0);
    checkOutput("and_pc_result", out_result, 32'h0000_5600);
    issueOne(ALU_ORO, OPR1_ZERO, OPR2_IMM, BR_NONE, 32'hFFFF_FFFF, 32'h0,
             32'h0, 32'h0000_00A5, 26, 1'b0);
    checkOutput("or_zero_result", out_result, 32'h0000_00A5);

    // Back-to-back A, B, C with the downstream stalled for two cycles
    drainIdle();
    out_ready = 1'b0;
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd10, 32'd0, 32'h0,
                  32'd0, 1, 1'b0);
    tick();
    checkOutput("bb_a_valid", 32'(out_valid), 32'd1);
    checkOutput("bb_a_tag", 32'(out_tag), 32'd1);
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd20, 32'd0, 32'h0,
                  32'd0, 2, 1'b0);
    tick();
    checkOutput("bb_hold_tag", 32'(out_tag), 32'd1);
    checkOutput("bb_skid_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd30, 32'd0, 32'h0,
                  32'd0, 3, 1'b0);
    tick();
    checkOutput("bb_stable_result", out_result, 32'd10);
    checkOutput("bb_stable_tag", 32'(out_tag), 32'd1);
    checkOutput("bb_c_wait_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("bb_b_tag", 32'(out_tag), 32'd2);
    checkOutput("bb_b_result", out_result, 32'd20);
    checkOutput("bb_b_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    checkOutput("bb_c_tag", 32'(out_tag), 32'd3);
    checkOutput("bb_c_result", out_result, 32'd30);
    checkOutput("bb_c_valid", 32'(out_valid), 32'd1);
    tick();
    checkOutput("bb_empty_valid", 32'(out_valid), 32'd0);

    // Flush with the out slot and skid both full and another uop offered
    drainIdle();
    out_ready = 1'b0;
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd40, 32'd0, 32'h0,
                  32'd0, 4, 1'b0);
    tick();
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd50, 32'd0, 32'h0,
                  32'd0, 5, 1'b0);
    tick();
    checkOutput("fl_full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd60, 32'd0, 32'h0,
                  32'd0, 6, 1'b0);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("fl_out_valid", 32'(out_valid), 32'd0);
    checkOutput("fl_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("fl_no_emit", 32'(out_valid), 32'd0);
    end

    // Reset in the middle of a stall, with flush and in_valid also high
    out_ready = 1'b0;
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd70, 32'd0, 32'h0,
                  32'd0, 7, 1'b0);
    tick();
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd80, 32'd0, 32'h0,
                  32'd0, 8, 1'b0);
    tick();
    applyStimulus(ALU_ADD, OPR1_RS1, OPR2_IMM, BR_NONE, 32'd90, 32'd0, 32'h0,
                  32'd0, 9, 1'b0);
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mrst_result", out_result, 32'd0);
    checkOutput("mrst_tag", 32'(out_tag), 32'd0);
    checkOutput("mrst_target", out_target, 32'd0);
    out_ready = 1'b1;
    tick();
    checkOutput("mrst_no_emit", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks_done, checks_failed);
    $finish;
  end

endmodule
